// File: rtl/pcm_rom_arbiter.sv
// ADPCM sample ROM arbiter: a one-word cache per channel (ADPCM-A / ADPCM-B),
// with cache misses arbitrated round-robin onto a single memory request/ack port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | serve hits on both channels; grant at most one pending miss
// ST_ISSUE | MEM_REQ held for the granted channel; the other channel's hits still served
module pcm_rom_arbiter #(
  parameter int   ADDR_W  = 24,
  parameter logic RR_INIT = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ROM_MASK,
  input  logic              FLUSH,
  input  logic              A_REQ,
  input  logic [ADDR_W-1:0] A_ADDR,
  output logic [7:0]        A_DATA,
  output logic              A_RDY,
  input  logic              B_REQ,
  input  logic [ADDR_W-1:0] B_ADDR,
  output logic [7:0]        B_DATA,
  output logic              B_RDY,
  output logic              MEM_REQ,
  output logic [ADDR_W-2:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_DATA
);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t            state, state_nxt;

  logic              a_pend, b_pend;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              a_valid, b_valid;
  logic [ADDR_W-2:0] a_tag, b_tag;
  logic [15:0]       a_word, b_word;

  logic              last_grant;   // 1 = B granted last
  logic              gnt;          // channel owning the in-flight fetch, 1 = B
  logic              ovr;          // granted channel's address replaced since grant

  logic              a_hit, b_hit, a_miss, b_miss;
  logic              a_serve, b_serve;
  logic              grant_go, grant_ch, grant_tie;
  logic              ack_go;

  always_comb begin
    a_hit     = a_pend & a_valid & ~FLUSH & (a_tag == a_addr[ADDR_W-1:1]);
    b_hit     = b_pend & b_valid & ~FLUSH & (b_tag == b_addr[ADDR_W-1:1]);
    a_miss    = a_pend & ~a_hit;
    b_miss    = b_pend & ~b_hit;
    // In ISSUE only the channel that does not own the fetch may be served.
    a_serve   = a_hit & ((state == ST_IDLE) | gnt);
    b_serve   = b_hit & ((state == ST_IDLE) | ~gnt);

    state_nxt = state;
    grant_go  = 1'b0;
    grant_ch  = gnt;
    grant_tie = 1'b0;
    ack_go    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (a_miss | b_miss) begin
          grant_go  = 1'b1;
          state_nxt = ST_ISSUE;
          if (a_miss & b_miss) begin
            grant_tie = 1'b1;
            grant_ch  = ~last_grant;
          end else begin
            grant_ch  = b_miss;
          end
        end
      end
      ST_ISSUE: begin
        if (MEM_ACK) begin
          ack_go    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_pend     <= 1'b0;
      b_pend     <= 1'b0;
      a_addr     <= '0;
      b_addr     <= '0;
      a_valid    <= 1'b0;
      b_valid    <= 1'b0;
      a_tag      <= '0;
      b_tag      <= '0;
      a_word     <= '0;
      b_word     <= '0;
      last_grant <= RR_INIT;
      gnt        <= 1'b0;
      ovr        <= 1'b0;
      MEM_REQ    <= 1'b0;
      MEM_ADDR   <= '0;
      A_RDY      <= 1'b0;
      B_RDY      <= 1'b0;
      A_DATA     <= '0;
      B_DATA     <= '0;
    end else begin
      A_RDY <= 1'b0;
      B_RDY <= 1'b0;

      if (grant_go) begin
        gnt      <= grant_ch;
        MEM_REQ  <= 1'b1;
        MEM_ADDR <= grant_ch ? b_addr[ADDR_W-1:1] : a_addr[ADDR_W-1:1];
        // A request landing in the grant cycle already supersedes the issued word.
        ovr      <= grant_ch ? B_REQ : A_REQ;
        if (grant_tie) last_grant <= grant_ch;
      end else if ((state == ST_ISSUE) && (gnt ? B_REQ : A_REQ)) begin
        ovr <= 1'b1;
      end

      if (ack_go) MEM_REQ <= 1'b0;

      // Flush first so a fill completing in the same cycle still lands valid.
      if (FLUSH) begin
        a_valid <= 1'b0;
        b_valid <= 1'b0;
      end

      if (ack_go) begin
        if (gnt) begin
          b_valid <= 1'b1;
          b_tag   <= MEM_ADDR;
          b_word  <= MEM_DATA;
        end else begin
          a_valid <= 1'b1;
          a_tag   <= MEM_ADDR;
          a_word  <= MEM_DATA;
        end
      end

      if (a_serve) begin
        A_RDY  <= 1'b1;
        A_DATA <= a_addr[0] ? a_word[15:8] : a_word[7:0];
        a_pend <= 1'b0;
      end else if (ack_go && !gnt && !ovr) begin
        A_RDY  <= 1'b1;
        A_DATA <= a_addr[0] ? MEM_DATA[15:8] : MEM_DATA[7:0];
        a_pend <= 1'b0;
      end

      if (b_serve) begin
        B_RDY  <= 1'b1;
        B_DATA <= b_addr[0] ? b_word[15:8] : b_word[7:0];
        b_pend <= 1'b0;
      end else if (ack_go && gnt && !ovr) begin
        B_RDY  <= 1'b1;
        B_DATA <= b_addr[0] ? MEM_DATA[15:8] : MEM_DATA[7:0];
        b_pend <= 1'b0;
      end

      // New requests win over a same-cycle completion.
      if (A_REQ) begin
        a_pend <= 1'b1;
        a_addr <= A_ADDR & ROM_MASK;
      end
      if (B_REQ) begin
        b_pend <= 1'b1;
        b_addr <= B_ADDR & ROM_MASK;
      end
    end
  end

endmodule

// File: tb/tb_pcm_rom_arbiter.sv
// Scoreboard bench for pcm_rom_arbiter: stimulus pushes expected bytes / memory
// word addresses (with expected cycle) into queues; monitors pop on RDY / MEM_REQ rise.
module tb_pcm_rom_arbiter;

  localparam int ADDR_W = 24;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [ADDR_W-1:0] ROM_MASK;
  logic              FLUSH;
  logic              A_REQ, B_REQ;
  logic [ADDR_W-1:0] A_ADDR, B_ADDR;
  logic [7:0]        A_DATA, B_DATA;
  logic              A_RDY, B_RDY;
  logic              MEM_REQ;
  logic [ADDR_W-2:0] MEM_ADDR;
  logic              MEM_ACK;
  logic [15:0]       MEM_DATA;

  pcm_rom_arbiter #(.ADDR_W(ADDR_W), .RR_INIT(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .ROM_MASK(ROM_MASK), .FLUSH(FLUSH),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_RDY(A_RDY),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_RDY(B_RDY),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] val;
    int          cyc;   // -1: cycle not checked
  } exp_t;

  exp_t qa[$], qb[$], qm[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic              prev_req = 1'b0;
  logic [ADDR_W-2:0] prev_addr = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void check_pop(input string name, ref exp_t q[$], input logic [31:0] got);
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected output %h at cycle %0d, nothing expected", name, got, cyc);
    end else begin
      e = q.pop_front();
      check(name, got, e.val);
      if (e.cyc >= 0) check({name, "_cycle"}, cyc, e.cyc);
    end
  endfunction

  always @(negedge CLK) begin
    if (A_RDY) check_pop("a_data", qa, {24'd0, A_DATA});
    if (B_RDY) check_pop("b_data", qb, {24'd0, B_DATA});
    if (MEM_REQ && !prev_req) check_pop("mem_addr", qm, {9'd0, MEM_ADDR});
    if (MEM_REQ && prev_req) check("mem_addr_hold", {9'd0, MEM_ADDR}, {9'd0, prev_addr});
    prev_req  = MEM_REQ;
    prev_addr = MEM_ADDR;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int ch, input logic [31:0] v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    if (ch == 0) qa.push_back(e);
    else if (ch == 1) qb.push_back(e);
    else qm.push_back(e);
  endtask

  task automatic req_a(input logic [ADDR_W-1:0] addr);
    A_REQ = 1'b1; A_ADDR = addr;
    tick();
    A_REQ = 1'b0;
  endtask

  task automatic req_b(input logic [ADDR_W-1:0] addr);
    B_REQ = 1'b1; B_ADDR = addr;
    tick();
    B_REQ = 1'b0;
  endtask

  // Wait for MEM_REQ, hold off 'hold' cycles, then ACK; ch=-1 expects no RDY.
  task automatic ack_after(input int hold, input logic [15:0] data, input int ch, input logic [7:0] bv);
    int n = 0;
    while (!MEM_REQ && n < 50) begin tick(); n++; end
    if (!MEM_REQ) begin
      n_tests++;
      n_fail++;
      $display("FAIL mem_req_timeout: MEM_REQ 0 after %0d cycles, expected 1", n);
    end
    repeat (hold) tick();
    MEM_ACK = 1'b1; MEM_DATA = data;
    if (ch >= 0) push(ch, {24'd0, bv}, cyc + 1);
    tick();
    MEM_ACK = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; ROM_MASK = 24'hFFFFFF; FLUSH = 1'b0;
    A_REQ = 1'b0; A_ADDR = '0; B_REQ = 1'b0; B_ADDR = '0;
    MEM_ACK = 1'b0; MEM_DATA = '0;
    repeat (3) tick();
    check("rst_a_rdy", {31'd0, A_RDY}, 32'd0);
    check("rst_b_rdy", {31'd0, B_RDY}, 32'd0);
    check("rst_mem_req", {31'd0, MEM_REQ}, 32'd0);
    check("rst_a_data", {24'd0, A_DATA}, 32'd0);
    check("rst_b_data", {24'd0, B_DATA}, 32'd0);
    check("rst_mem_addr", {9'd0, MEM_ADDR}, 32'd0);
    RESET = 1'b0;
    tick();

    // Miss, then hit on the other byte, then flush forces a refetch
    push(2, 32'h80, cyc + 2);
    req_a(24'h000100);
    ack_after(2, 16'hBEEF, 0, 8'hEF);
    push(0, 32'hBE, cyc + 2);
    req_a(24'h000101);
    repeat (3) tick();
    FLUSH = 1'b1; tick(); FLUSH = 1'b0;
    push(2, 32'h80, cyc + 2);
    req_a(24'h000101);
    ack_after(1, 16'hBEEF, 0, 8'hBE);
    repeat (2) tick();

    // Two-way tie: A first, then a fresh tie goes to B
    push(2, 32'h100, cyc + 2);
    push(2, 32'h200, -1);
    A_REQ = 1'b1; A_ADDR = 24'h000200; B_REQ = 1'b1; B_ADDR = 24'h000400;
    tick();
    A_REQ = 1'b0; B_REQ = 1'b0;
    ack_after(1, 16'h1122, 0, 8'h22);
    ack_after(1, 16'h3344, 1, 8'h44);
    repeat (2) tick();
    push(2, 32'h400, cyc + 2);
    push(2, 32'h300, -1);
    A_REQ = 1'b1; A_ADDR = 24'h000600; B_REQ = 1'b1; B_ADDR = 24'h000800;
    tick();
    A_REQ = 1'b0; B_REQ = 1'b0;
    ack_after(0, 16'h5566, 1, 8'h66);
    ack_after(0, 16'h7788, 0, 8'h88);
    repeat (2) tick();

    // B hit served while A's fetch is outstanding
    push(2, 32'h500, cyc + 2);
    req_a(24'h000A00);
    tick();
    push(1, 32'h55, cyc + 2);
    req_b(24'h000801);
    ack_after(4, 16'hAB9A, 0, 8'h9A);
    repeat (2) tick();

    // Address masking and aliasing
    ROM_MASK = 24'h0FFFFF;
    push(2, 32'h011A2B, cyc + 2);
    req_a(24'h123456);
    ack_after(0, 16'hC3D4, 0, 8'hD4);
    push(0, 32'hC3, cyc + 2);
    req_a(24'h323457);
    repeat (3) tick();
    ROM_MASK = 24'hFFFFFF;

    // Overwrite during ISSUE: first ACK silent, refetch, single RDY
    push(2, 32'h8, cyc + 2);
    req_a(24'h000010);
    tick();
    req_a(24'h000300);
    push(2, 32'h180, -1);
    ack_after(1, 16'h0F0E, -1, 8'h00);
    ack_after(1, 16'h2468, 0, 8'h68);
    repeat (3) tick();

    // Reset mid-ISSUE; late ACK must be ignored
    push(2, 32'h700, cyc + 2);
    req_a(24'h000E00);
    repeat (2) tick();
    RESET = 1'b1;
    tick();
    check("reset_drops_mem_req", {31'd0, MEM_REQ}, 32'd0);
    RESET = 1'b0;
    tick();
    MEM_ACK = 1'b1; MEM_DATA = 16'hFFFF;
    tick();
    MEM_ACK = 1'b0;
    repeat (5) tick();
    check("late_ack_mem_req", {31'd0, MEM_REQ}, 32'd0);

    check("qa_drained", qa.size(), 32'd0);
    check("qb_drained", qb.size(), 32'd0);
    check("qm_drained", qm.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_rom_arbiter.md
Name: pcm_rom_arbiter

Overview:
- Shares the single ADPCM sample ROM backend (SDRAM port) between the ADPCM-A and ADPCM-B byte fetchers.
- Each channel requests one byte at a 24-bit byte address, which is the address the PCM bus demux assembles.
- The block keeps a one-word (16-bit) cache per channel and arbitrates cache misses round-robin onto one memory request/ack port.
- It returns the byte with a one-cycle ready pulse.

Parameters:
ADDR_W, 24, byte address width for both channels and ROM_MASK
RR_INIT, 1'b1, initial value of LAST_GRANT after reset (1 = B granted last, so A wins first tie)

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
ROM_MASK  in  ADDR_W  ROM size minus 1; channel addresses are ANDed with it before use
FLUSH  in  1  one-cycle pulse; invalidates both channel caches
A_REQ  in  1  one-cycle pulse; request byte at A_ADDR
A_ADDR  in  ADDR_W  ADPCM-A byte address, sampled when A_REQ=1
A_DATA  out  8  returned byte, valid when A_RDY=1, held until next A_RDY
A_RDY  out  1  one-cycle pulse
B_REQ, B_ADDR, B_DATA, B_RDY  same as the A_* ports, for ADPCM-B
MEM_REQ  out  1  request to the ROM backend; level
MEM_ADDR  out  ADDR_W-1  word address (masked byte address bits [ADDR_W-1:1])
MEM_ACK  in  1  one-cycle pulse; MEM_DATA valid in that cycle
MEM_DATA  in  16  fetched word; byte 0 = [7:0], byte 1 = [15:8]

Behaviour:
- Reset values:
  - A_RDY, B_RDY, MEM_REQ = 0.
  - A_DATA, B_DATA, MEM_ADDR = 0.
  - Pending flags and cache valid flags = 0.
  - LAST_GRANT = RR_INIT. FSM = IDLE.
- Request capture:
  - REQ=1 sets the channel pending flag and latches addr & ROM_MASK.
  - REQ while already pending overwrites the address; latest wins, and only one RDY is produced.
  - REQ in the same cycle the channel's RDY fires sets pending again.
- Cache hit: the channel is pending and its cache is valid and cached word address == masked addr[ADDR_W-1:1].
- FSM states: IDLE, ISSUE.
- IDLE:
  - Hits on A and B are each served in the same cycle, independently; both may complete together.
  - On a hit: RDY=1 next cycle, DATA = selected byte (addr[0] picks [15:8] when 1), pending cleared.
  - Otherwise, if any miss is pending, grant one miss. With two misses, grant the channel != LAST_GRANT, then update LAST_GRANT.
  - A hit on one channel and a miss on the other in the same cycle: the hit is served and the miss is granted in that same cycle.
  - On grant: MEM_ADDR = word address, MEM_REQ=1 from the next cycle. Go to ISSUE.
- ISSUE:
  - MEM_REQ and MEM_ADDR are held stable until MEM_ACK=1 is sampled. MEM_ACK is legal in the first cycle MEM_REQ is high.
  - On ACK: MEM_REQ=0 next cycle, and the granted channel's cache is written (word addr, data, valid=1).
  - Also on ACK: RDY=1 next cycle with the selected byte, pending cleared, return to IDLE.
  - If the granted channel's address was overwritten during ISSUE, the ACK still fills the cache but does NOT clear pending or pulse RDY. Pending is re-evaluated in IDLE, as a hit or a new miss.
  - The non-granted channel's hits continue to be served during ISSUE.
- MEM_ACK outside ISSUE is ignored.
- Latency:
  - Hit: REQ in cycle c0 gives RDY in c2.
  - Miss with no contention: MEM_REQ high from c2; ACK in cycle k gives RDY in k+1.
- FLUSH:
  - Clears both valid flags in that cycle. FLUSH takes priority over a same-cycle hit decision, which becomes a miss.
  - An in-flight fill completing after FLUSH still writes the cache as valid.
- Address wrap: ROM_MASK is applied before caching and issue. Addresses beyond the ROM size alias.
- RESET mid-ISSUE:
  - MEM_REQ=0 on the next cycle and the request is abandoned; the backend must tolerate this.
  - A late MEM_ACK is ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then A_REQ addr 0x000100, ROM_MASK 0xFFFFFF -> MEM_REQ=1, MEM_ADDR=0x000080 in c2. MEM_ACK with MEM_DATA=0xBEEF two cycles later -> A_RDY one cycle, A_DATA=0xEF.
- Follow with A_REQ addr 0x000101 -> no MEM_REQ, A_RDY in c2, A_DATA=0xBE. Then FLUSH, then same address -> MEM_REQ reissued.
- A_REQ 0x000200 and B_REQ 0x000400 in the same cycle, both miss -> A granted first (MEM_ADDR 0x000100), B next (0x000200). A repeat tie with fresh misses -> B granted first.
- A in ISSUE (ACK held off 5 cycles) and B_REQ hits its cache -> B_RDY in c2 while MEM_REQ stays high and MEM_ADDR is unchanged.
- ROM_MASK 0x0FFFFF, A_REQ 0x123456 -> MEM_ADDR=0x011A2B.
- A_REQ 0x000010 then A_REQ 0x000300 during ISSUE; ACK -> no A_RDY on that ACK, second miss issued for 0x000180, single A_RDY after its ACK. RESET during a further ISSUE -> MEM_REQ=0 next cycle, late ACK produces no RDY.
